// File: rtl/hilo_muldiv_seq.sv
// HI/LO owner and multi-cycle MULT/MULTU/DIV/DIVU sequencer; stalls the pipeline while iterating.
// Optional build macro MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module hilo_muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   bmag;
  logic [CW-1:0]      cnt;
  logic               sgn, neg_q, neg_r;

  logic               idle_like, accept, last_cnt, mul_last;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_sum, mul_res;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               qbit;
  logic [WIDTH-1:0]   rem_nx, quo_nx, rem_fix, quo_fix;

  always_comb begin
    idle_like = (state == IDLE) || (state == DONE);
    accept    = start_i && idle_like && !flush_i;
    busy_o    = (state == MUL) || (state == DIV);
    done_o    = (state == DONE);
    stall_o   = accept || busy_o;

    a_neg = !op_i[0] && a_i[WIDTH-1];
    b_neg = !op_i[0] && b_i[WIDTH-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;

    last_cnt = (cnt == CW'(WIDTH-1));
    mul_sum  = acc + (bmag[0] ? mcand : '0);
`ifdef MULDIV_EARLY_OUT_EN
    mul_last = last_cnt || (bmag[WIDTH-1:1] == '0);
`else
    mul_last = last_cnt;
`endif
    mul_res = (sgn && neg_q) ? -mul_sum : mul_sum;

    // Restoring step: remainder lives in acc upper half, dividend/quotient in the lower half.
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, bmag};
    qbit      = !div_diff[WIDTH];
    rem_nx    = qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_nx    = {acc[WIDTH-2:0], qbit};
    quo_fix   = (sgn && neg_q) ? -quo_nx : quo_nx;
    rem_fix   = (sgn && neg_r) ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      bmag  <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (hi_we_i) hi_o <= wdata_i;
          if (lo_we_i) lo_o <= wdata_i;
          state <= IDLE;
          if (start_i) begin
            acc   <= op_i[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
            mcand <= {{WIDTH{1'b0}}, a_mag};
            bmag  <= b_mag;
            cnt   <= '0;
            sgn   <= !op_i[0];
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            // Divide by zero resolves at the accept edge, overriding any coincident MTHI/MTLO.
            if (op_i[1] && (b_i == '0)) begin
              lo_o  <= '1;
              hi_o  <= a_i;
              state <= DONE;
            end else begin
              state <= op_i[1] ? DIV : MUL;
            end
          end
        end
        MUL: begin
          acc   <= mul_sum;
          mcand <= mcand << 1;
          bmag  <= bmag >> 1;
          cnt   <= cnt + 1'b1;
          if (mul_last) begin
            hi_o  <= mul_res[2*WIDTH-1:WIDTH];
            lo_o  <= mul_res[WIDTH-1:0];
            state <= DONE;
          end
        end
        DIV: begin
          acc <= {rem_nx, quo_nx};
          cnt <= cnt + 1'b1;
          if (last_cnt) begin
            lo_o  <= quo_fix;
            hi_o  <= rem_fix;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed bench for hilo_muldiv_seq: latency, results, flush, MTHI/MTLO, reset behaviour.
module tb_hilo_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i, flush_i, hi_we_i, lo_we_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i, wdata_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  hilo_muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle, count stall cycles, then check the DONE cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int elat,
                       input string tag);
    int n;
    n = 0;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    #1;
    while (stall_o === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      #1;
    end
    chk($sformatf("%s_latency", tag), 64'(n), 64'(elat));
    chk($sformatf("%s_done", tag), 64'(done_o), 64'd1);
    chk($sformatf("%s_hi", tag), 64'(hi_o), 64'(ehi));
    chk($sformatf("%s_lo", tag), 64'(lo_o), 64'(elo));
  endtask

  initial begin
    int n;
    int mult_lat;
`ifdef MULDIV_EARLY_OUT_EN
    mult_lat = 3;
`else
    mult_lat = 33;
`endif
    reset = 1'b0; start_i = 1'b0; flush_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    op_i = 2'b00; a_i = '0; b_i = '0; wdata_i = '0;
    #12;
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    step();
    reset = 1'b1;
    step();

    // MTLO / MTHI in IDLE
    lo_we_i = 1'b1; wdata_i = 32'hA5A5A5A5;
    step();
    lo_we_i = 1'b0;
    #1;
    chk("mtlo_lo", 64'(lo_o), 64'hA5A5A5A5);
    chk("mtlo_hi", 64'(hi_o), 64'd0);
    hi_we_i = 1'b1; wdata_i = 32'h5A5A0001;
    step();
    hi_we_i = 1'b0;
    #1;
    chk("mthi_hi", 64'(hi_o), 64'h5A5A0001);

    // flush beats start
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_MULT; a_i = 32'd3; b_i = 32'd3;
    #1;
    chk("flushstart_stall", 64'(stall_o), 64'd0);
    step();
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("flushstart_busy", 64'(busy_o), 64'd0);

    do_op(OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, mult_lat, "mult_neg2x3");
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, "multu_max");
    do_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div_m7by2");
    do_op(OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 33, "divu_7by2");
    do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, "div_ovf");
    do_op(OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1,  "divu_by0");

    // MULT aborted by flush at T+5
    start_i = 1'b1; op_i = OP_MULT; a_i = 32'd3; b_i = 32'd4;
    #1;
    step();
    start_i = 1'b0;
    repeat (4) step();
    flush_i = 1'b1;
    #1;
    chk("flush_stall_t5", 64'(stall_o), 64'd1);
    step();
    flush_i = 1'b0;
    #1;
    chk("flush_busy", 64'(busy_o), 64'd0);
    chk("flush_stall", 64'(stall_o), 64'd0);
    chk("flush_hi", 64'(hi_o), 64'h1234);
    chk("flush_lo", 64'(lo_o), 64'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      chk("flush_nodone", 64'(done_o), 64'd0);
      step();
    end

    // MTLO/MTHI ignored while busy, then back-to-back start in the DONE cycle
    start_i = 1'b1; op_i = OP_MULTU; a_i = 32'd5; b_i = 32'd7;
    #1;
    step();
    start_i = 1'b0;
    step();
    lo_we_i = 1'b1; hi_we_i = 1'b1; wdata_i = 32'hDEADBEEF;
    #1;
    chk("busywr_stall", 64'(stall_o), 64'd1);
    step();
    lo_we_i = 1'b0; hi_we_i = 1'b0;
    #1;
    chk("busywr_lo", 64'(lo_o), 64'hFFFFFFFF);
    chk("busywr_hi", 64'(hi_o), 64'h1234);
    n = 0;
    while (done_o !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("multu5x7_done", 64'(done_o), 64'd1);
    chk("multu5x7_lo", 64'(lo_o), 64'd35);
    chk("multu5x7_hi", 64'(hi_o), 64'd0);
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, "divu_b2b");

    // async reset in cycle T+10 of a DIV
    step();
    start_i = 1'b1; op_i = OP_DIV; a_i = 32'd1000; b_i = 32'd3;
    #1;
    step();
    start_i = 1'b0;
    repeat (9) step();
    chk("middiv_busy_pre", 64'(busy_o), 64'd1);
    reset = 1'b0;
    #1;
    chk("middiv_rst_busy", 64'(busy_o), 64'd0);
    chk("middiv_rst_hi", 64'(hi_o), 64'd0);
    chk("middiv_rst_lo", 64'(lo_o), 64'd0);
    step();
    chk("middiv_rst_stall", 64'(stall_o), 64'd0);
    chk("middiv_rst_done", 64'(done_o), 64'd0);
    reset = 1'b1;
    step();
    do_op(OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1, "postrst_div0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_seq.md
Name: hilo_muldiv_seq

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU. Owns the architectural HI/LO registers.
- Sits beside the EX stage and drives `stall_o`. The hazard logic ANDs `stall_o` (inverted) into the enable inputs of the IF/ID/EX pipeline enable-registers, freezing the pipeline while an iterative operation runs.
- Also services MTHI/MTLO writes and presents HI/LO to MFHI/MFLO.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start_i  in  1  EX stage holds a mul/div instruction this cycle.
- op_i  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start_i.
- a_i  in  WIDTH  rs operand (multiplicand/dividend).
- b_i  in  WIDTH  rt operand (multiplier/divisor).
- flush_i  in  1  abort current operation (exception/branch flush).
- hi_we_i  in  1  MTHI write enable.
- lo_we_i  in  1  MTLO write enable.
- wdata_i  in  WIDTH  MTHI/MTLO data.
- stall_o  out  1  freeze pipeline enables.
- busy_o  out  1  FSM in MUL or DIV state.
- done_o  out  1  one-cycle pulse; HI/LO updated with a new result.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; hi_o=lo_o=0; iteration counter=0; internal accumulators=0.
  - stall_o, busy_o and done_o all read 0.
- States: IDLE, MUL, DIV, DONE. Encoding is free.
- Accept:
  - In IDLE or DONE with start_i=1 and flush_i=0, latch the operand magnitudes and sign info, clear the counter, and go to MUL (op_i[1]=0) or DIV (op_i[1]=1).
  - Signed ops (op_i[0]=0) take two's-complement magnitudes. Record neg_q = sign(a) XOR sign(b) and neg_r = sign(a).
- stall_o:
  - Combinational: (start_i AND state in {IDLE,DONE} AND NOT flush_i) OR busy_o.
  - It is high in the acceptance cycle T so EX holds the instruction.
- MUL:
  - Unsigned shift-add over |b| LSB-first, one bit per cycle, 2*WIDTH-bit accumulator.
  - The counter runs 0..WIDTH-1. On the last iteration, apply sign fix: negate the 64-bit product if neg_q and signed. Then write HI=upper and LO=lower, and go to DONE.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles.
  - On the last iteration: LO = quotient (negated if neg_q and signed), HI = remainder (negated if neg_r and signed). Go to DONE.
- Latency:
  - Accept in cycle T; iterations in cycles T+1..T+WIDTH; stall_o high for cycles T..T+WIDTH (33 cycles at default).
  - HI/LO update at the edge ending T+WIDTH. In cycle T+WIDTH+1, state=DONE, done_o=1, stall_o=0.
- DONE lasts one cycle, then returns to IDLE unless a new start is accepted (back-to-back allowed).
- Divide by zero (b=0, DIV/DIVU):
  - No iteration: at the acceptance edge, LO=all-ones and HI=a_i, then go directly to DONE.
  - Latency 1, stall_o high in cycle T only.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. This is the natural result of the magnitude path; no trap.
- flush_i:
  - In any state, go to IDLE at the next edge. HI/LO are not modified; no done_o.
  - flush_i has priority over start_i and over the final-iteration write.
- MTHI/MTLO:
  - In IDLE/DONE, hi_we_i/lo_we_i write wdata_i at the edge.
  - Ignored while busy_o=1.
  - If a write coincides with accept, the write lands now and is overwritten by the result later.
- MFHI/MFLO read hi_o/lo_o directly; the pipeline is stalled while they are stale.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- When defined: MUL terminates as soon as the remaining unshifted multiplier bits are all zero, with a minimum of 1 iteration. The final write and the transition to DONE happen on that iteration. Example: |b|=3 completes after 2 iterations, stall_o high for 3 cycles.
- When undefined: MUL always takes WIDTH iterations. DIV is unaffected in both builds.

Test Plan:
- Reset low mid-DIV (cycle T+10) → next cycle state IDLE, hi_o=lo_o=0, stall_o=0; after release, start_i with idle inputs produces stall_o=1.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 → stall_o high 33 cycles; done_o pulse at T+33; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU same operands → LO=0x7FFFFFFC, HI=1.
- DIVU a=0x1234, b=0 → done_o at T+1, LO=0xFFFFFFFF, HI=0x1234; then flush_i asserted at T+5 of a subsequent MULT → IDLE, HI/LO unchanged, no done_o.
- MTLO wdata=0xA5A5A5A5 in IDLE → lo_o=0xA5A5A5A5 next cycle; lo_we_i while busy → lo_o unchanged; back-to-back start in DONE cycle accepted with no idle gap.
